fmap_readout_256: RTL and testbench
===================================

FMAP_READOUT_256 -- requirements
Module: fmap_readout_256

Interface
REQ-001 Parameter DATA_WIDTH, 16, pixel width in bits.
REQ-002 Parameter PIX_H, 24, pixels per column.
REQ-003 Parameter NUM_COLS, 24, columns per feature map.
REQ-004 Parameter BASE_ADDR, 12'h000, BRAM word address of column 0.
REQ-005 Derived constant WORDS_PER_COL = ceil(PIX_H*DATA_WIDTH/256); LANES = 256/DATA_WIDTH.
REQ-006 out_stream_aclk input 1, clock; periph_resetn input 1, reset, asynchronous, active-low.
REQ-007 start input 1, single-cycle pulse requesting one full map readout.
REQ-008 bram_addr_b output 12, BRAM read word address.
REQ-009 bram_en_b output 1, BRAM read enable.
REQ-010 bram_rddata_b input 256, BRAM read data, valid exactly 1 cycle after the address/enable edge.
REQ-011 col_data output PIX_H x DATA_WIDTH (unpacked array), current column, pixel 0 at row 0.
REQ-012 col_valid output 1, col_data valid; col_ready input 1, consumer accepts.
REQ-013 col_last output 1, high with col_valid on column NUM_COLS-1.
REQ-014 col_index output clog2(NUM_COLS), index of the presented column.
REQ-015 busy output 1, high from the cycle after start acceptance until done; done output 1, one-cycle pulse.

Function
REQ-016 Memory layout: column c occupies words BASE_ADDR + c*WORDS_PER_COL + k, k = 0..WORDS_PER_COL-1; pixel p is in word p/LANES, bits [DATA_WIDTH*(p%LANES) +: DATA_WIDTH]; unused upper lanes of the last word are ignored.
REQ-017 FSM states: IDLE, READ, WAIT, PRESENT, DONE.
REQ-018 IDLE: start high -> READ, column counter = 0, word counter = 0; start in any other state is ignored.
REQ-019 READ: drive bram_en_b = 1 and the address of word k each cycle, k increments each cycle; after issuing k = WORDS_PER_COL-1 -> WAIT.
REQ-020 The word returned for address k is stored into pixel slots LANES*k .. min(LANES*(k+1), PIX_H)-1 on the cycle it is returned.
REQ-021 WAIT: capture the final word, then -> PRESENT; col_valid rises WORDS_PER_COL+2 cycles after the start edge for column 0.
REQ-022 PRESENT: col_valid = 1; col_data, col_last and col_index held stable until col_valid && col_ready at a clock edge.
REQ-023 On handshake of a non-last column: increment column counter, -> READ, col_valid = 0 on the next cycle (no back-to-back columns; one bubble per column minimum).
REQ-024 On handshake of column NUM_COLS-1: -> DONE; DONE asserts done for one cycle, deasserts busy, -> IDLE.
REQ-025 bram_en_b = 0 and bram_addr_b = 0 in all states except READ.
REQ-026 col_ready held low indefinitely stalls in PRESENT with no BRAM activity and no data change.
REQ-027 col_ready high before col_valid has no effect.
REQ-028 start coincident with done is ignored (IDLE not yet entered).
REQ-029 Address arithmetic is 12-bit unsigned, wraps modulo 4096; BASE_ADDR + NUM_COLS*WORDS_PER_COL exceeding 4096 is a configuration error, flagged by a simulation-only assertion.

Reset
REQ-030 On periph_resetn low, at any time including mid-column: state = IDLE, counters = 0, col_data = 0, col_valid = 0, col_last = 0, col_index = 0, busy = 0, done = 0, bram_en_b = 0, bram_addr_b = 0.
REQ-031 After reset release, no output changes until a new start pulse.

Structure
REQ-032 A shared package holds the state enum, the 256-bit BRAM word width and the DATA_WIDTH/LANES constants, shared with the write-side capture block.
REQ-033 Single module, no sub-modules; lane unpacking is a generate loop inside the module.

Verification
REQ-034 BRAM model preloaded with pixel value = c*256 + p, default params, col_ready tied high -> 24 columns, each col_data[p] = c*256+p, col_last only on col_index 23, done pulse once, first col_valid 4 cycles after start.
REQ-035 col_ready low for 10 cycles on column 5 -> col_valid stays high, col_data and col_index = 5 stable, bram_en_b = 0 throughout the stall.
REQ-036 PIX_H=10, NUM_COLS=10, BASE_ADDR=12'h020 -> WORDS_PER_COL=1, column c read from address 0x020+c, first col_valid 3 cycles after start.
REQ-037 periph_resetn asserted while in READ on column 7 -> all outputs zero next edge; new start reads from column 0.
REQ-038 start pulsed while busy and again coincident with done -> ignored, exactly NUM_COLS handshakes occur, single done pulse.

Source files
------------

// File: rtl/fmap_readout_256_pkg.sv
// rtl/fmap_readout_256_pkg.sv - shared constants, state enum and sizing helpers for feature-map BRAM access
package fmap_readout_256_pkg;

    localparam int BRAM_WIDTH      = 256;
    localparam int BRAM_ADDR_WIDTH = 12;
    localparam int FMAP_DATA_WIDTH = 16;
    localparam int FMAP_LANES      = BRAM_WIDTH / FMAP_DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_PRESENT,
        ST_DONE
    } fmap_state_t;

    function automatic int lanes_for(int data_width);
        return BRAM_WIDTH / data_width;
    endfunction

    function automatic int words_per_col(int pix_h, int data_width);
        return (pix_h * data_width + BRAM_WIDTH - 1) / BRAM_WIDTH;
    endfunction

    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_readout_256_if.sv
// rtl/fmap_readout_256_if.sv - BRAM read port plus column stream between readout engine and consumer
interface fmap_readout_256_if
    import fmap_readout_256_pkg::*;
#(
    parameter int DATA_WIDTH = FMAP_DATA_WIDTH,
    parameter int PIX_H      = 24,
    parameter int NUM_COLS   = 24
) ();

    localparam int IDX_W = idx_width(NUM_COLS);

    logic [BRAM_ADDR_WIDTH-1:0] bram_addr_b;
    logic                       bram_en_b;
    logic [BRAM_WIDTH-1:0]      bram_rddata_b;

    logic [DATA_WIDTH-1:0]      col_data [PIX_H];
    logic                       col_valid;
    logic                       col_ready;
    logic                       col_last;
    logic [IDX_W-1:0]           col_index;

    modport master (
        output bram_addr_b,
        output bram_en_b,
        input  bram_rddata_b,
        output col_data,
        output col_valid,
        input  col_ready,
        output col_last,
        output col_index
    );

    modport slave (
        input  bram_addr_b,
        input  bram_en_b,
        output bram_rddata_b,
        input  col_data,
        input  col_valid,
        output col_ready,
        input  col_last,
        input  col_index
    );

endinterface

// File: rtl/fmap_readout_256.sv
// rtl/fmap_readout_256.sv - reads a column-major feature map from 256-bit BRAM and presents one column at a time
module fmap_readout_256
    import fmap_readout_256_pkg::*;
#(
    parameter int                         DATA_WIDTH = FMAP_DATA_WIDTH,
    parameter int                         PIX_H      = 24,
    parameter int                         NUM_COLS   = 24,
    parameter logic [BRAM_ADDR_WIDTH-1:0] BASE_ADDR  = 12'h000
) (
    input  logic                 out_stream_aclk,
    input  logic                 periph_resetn,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    fmap_readout_256_if.master   bus
);

    localparam int WORDS_PER_COL = words_per_col(PIX_H, DATA_WIDTH);
    localparam int LANES         = lanes_for(DATA_WIDTH);
    localparam int WORD_W        = idx_width(WORDS_PER_COL);
    localparam int IDX_W         = idx_width(NUM_COLS);
    localparam int ADDR_END      = int'(BASE_ADDR) + NUM_COLS * WORDS_PER_COL;

    localparam logic [BRAM_ADDR_WIDTH-1:0] WPC_ADDR  = BRAM_ADDR_WIDTH'(WORDS_PER_COL);
    localparam logic [WORD_W-1:0]          LAST_WORD = WORD_W'(WORDS_PER_COL - 1);
    localparam logic [IDX_W-1:0]           LAST_COL  = IDX_W'(NUM_COLS - 1);

    fmap_state_t                 state;
    fmap_state_t                 state_nxt;
    logic [WORD_W-1:0]           word_cnt;
    logic [IDX_W-1:0]            col_cnt;
    logic [BRAM_ADDR_WIDTH-1:0]  col_addr;
    logic                        cap_en;
    logic [WORD_W-1:0]           cap_word;
    logic                        unused_rddata;

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_READ;
            ST_READ:    if (word_cnt == LAST_WORD) state_nxt = ST_WAIT;
            ST_WAIT:    state_nxt = ST_PRESENT;
            ST_PRESENT: if (bus.col_ready) state_nxt = (col_cnt == LAST_COL) ? ST_DONE : ST_READ;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // col_addr tracks BASE_ADDR + col*WORDS_PER_COL incrementally so no multiplier is needed
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            word_cnt <= '0;
            col_cnt  <= '0;
            col_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        word_cnt <= '0;
                        col_cnt  <= '0;
                        col_addr <= BASE_ADDR;
                    end
                end
                ST_READ: begin
                    word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
                end
                ST_PRESENT: begin
                    if (bus.col_ready && col_cnt != LAST_COL) begin
                        col_cnt  <= col_cnt + 1'b1;
                        col_addr <= col_addr + WPC_ADDR;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data lags the address by one cycle: word k-1 lands while word k is issued, the last one in WAIT
    always_comb begin
        cap_en   = 1'b0;
        cap_word = '0;
        if (state == ST_READ && word_cnt != '0) begin
            cap_en   = 1'b1;
            cap_word = word_cnt - 1'b1;
        end else if (state == ST_WAIT) begin
            cap_en   = 1'b1;
            cap_word = LAST_WORD;
        end
    end

    for (genvar p = 0; p < PIX_H; p++) begin : g_pix
        localparam int WORD = p / LANES;
        localparam int LANE = p % LANES;
        logic [DATA_WIDTH-1:0] pix_q;

        always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
            if (!periph_resetn) begin
                pix_q <= '0;
            end else if (cap_en && cap_word == WORD_W'(WORD)) begin
                pix_q <= bus.bram_rddata_b[DATA_WIDTH*LANE +: DATA_WIDTH];
            end
        end

        assign bus.col_data[p] = pix_q;
    end

    // Lanes beyond PIX_H in the last word of a column carry no pixels
    assign unused_rddata = ^bus.bram_rddata_b;

    assign bus.bram_en_b   = (state == ST_READ);
    assign bus.bram_addr_b = (state == ST_READ) ? col_addr + BRAM_ADDR_WIDTH'(word_cnt) : '0;
    assign bus.col_valid   = (state == ST_PRESENT);
    assign bus.col_last    = (state == ST_PRESENT) && (col_cnt == LAST_COL);
    assign bus.col_index   = col_cnt;
    assign busy            = (state == ST_READ) || (state == ST_WAIT) || (state == ST_PRESENT);
    assign done            = (state == ST_DONE);

    cfg_addr_span: assert property (@(posedge out_stream_aclk) ADDR_END <= 4096);

endmodule

// File: tb/tb_fmap_readout_256.sv
// tb/tb_fmap_readout_256.sv - scoreboard bench for fmap_readout_256 in default and small configurations
module tb_fmap_readout_256;
    import fmap_readout_256_pkg::*;

    localparam int A_PIX  = 24;
    localparam int A_COLS = 24;
    localparam int B_PIX  = 10;
    localparam int B_COLS = 10;
    localparam int B_BASE = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic ready_a = 1'b1, ready_b = 1'b1;
    logic busy_a, done_a, busy_b, done_b;
    logic [255:0] rd_a = '0, rd_b = '0;
    logic [255:0] mem_a [4096];
    logic [255:0] mem_b [4096];

    int checks = 0, failures = 0;
    int cyc = 0, s_cyc = 0;
    int q_a[$], q_b[$];
    int hs_a = 0, hs_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    int rd_a_n = 0, rd_b_n = 0;
    int ca, cb, bad_a, bad_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fmap_readout_256_if #(.DATA_WIDTH(16), .PIX_H(A_PIX), .NUM_COLS(A_COLS)) ia ();
    fmap_readout_256_if #(.DATA_WIDTH(16), .PIX_H(B_PIX), .NUM_COLS(B_COLS)) ib ();

    fmap_readout_256 #(.DATA_WIDTH(16), .PIX_H(A_PIX), .NUM_COLS(A_COLS), .BASE_ADDR(12'h000)) dut_a (
        .out_stream_aclk(clk), .periph_resetn(resetn), .start(start_a),
        .busy(busy_a), .done(done_a), .bus(ia));

    fmap_readout_256 #(.DATA_WIDTH(16), .PIX_H(B_PIX), .NUM_COLS(B_COLS), .BASE_ADDR(12'h020)) dut_b (
        .out_stream_aclk(clk), .periph_resetn(resetn), .start(start_b),
        .busy(busy_b), .done(done_b), .bus(ib));

    always @(posedge clk) if (ia.bram_en_b) rd_a <= mem_a[ia.bram_addr_b];
    always @(posedge clk) if (ib.bram_en_b) rd_b <= mem_b[ib.bram_addr_b];
    assign ia.bram_rddata_b = rd_a;
    assign ib.bram_rddata_b = rd_b;
    assign ia.col_ready = ready_a;
    assign ib.col_ready = ready_b;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop one expected column per handshake
    always @(negedge clk) begin
        if (resetn && ia.col_valid && ia.col_ready) begin
            hs_a++;
            check("a_expected_pending", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                ca = q_a.pop_front();
                check("a_col_index", ia.col_index, ca);
                check("a_col_last", ia.col_last, int'(ca == A_COLS - 1));
                bad_a = 0;
                for (int p = 0; p < A_PIX; p++) if (ia.col_data[p] != 16'(ca * 256 + p)) bad_a++;
                check("a_col_data_bad_pixels", bad_a, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && ib.col_valid && ib.col_ready) begin
            hs_b++;
            check("b_expected_pending", int'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                cb = q_b.pop_front();
                check("b_col_index", ib.col_index, cb);
                check("b_col_last", ib.col_last, int'(cb == B_COLS - 1));
                bad_b = 0;
                for (int p = 0; p < B_PIX; p++) if (ib.col_data[p] != 16'(cb * 256 + p)) bad_b++;
                check("b_col_data_bad_pixels", bad_b, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (ia.bram_en_b) begin
            check("a_bram_addr", ia.bram_addr_b, rd_a_n);
            rd_a_n++;
        end
        if (ib.bram_en_b) begin
            check("b_bram_addr", ib.bram_addr_b, B_BASE + rd_b_n);
            rd_b_n++;
        end
    end

    task automatic do_start_a();
        @(posedge clk); #1;
        start_a = 1'b1; s_cyc = cyc; rd_a_n = 0;
        for (int c = 0; c < A_COLS; c++) q_a.push_back(c);
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic do_start_b();
        @(posedge clk); #1;
        start_b = 1'b1; s_cyc = cyc; rd_b_n = 0;
        for (int c = 0; c < B_COLS; c++) q_b.push_back(c);
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    task automatic check_zero_a(string tag);
        int nz = 0;
        for (int p = 0; p < A_PIX; p++) if (ia.col_data[p] != '0) nz++;
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_col_valid"}, ia.col_valid, 0);
        check({tag, "_col_last"}, ia.col_last, 0);
        check({tag, "_col_index"}, ia.col_index, 0);
        check({tag, "_bram_en"}, ia.bram_en_b, 0);
        check({tag, "_bram_addr"}, ia.bram_addr_b, 0);
        check({tag, "_nonzero_pixels"}, nz, 0);
    endtask

    task automatic wait_done_a(int target);
        int t = 0;
        do begin @(negedge clk); t++; end while (done_cnt_a < target && t < 2000);
        repeat (3) @(negedge clk);
        check("a_done_count", done_cnt_a, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] w;
        int t;
        int hs0;

        for (int a = 0; a < 4096; a++) begin
            mem_a[a] = {16{16'hDEAD}};
            mem_b[a] = {16{16'hDEAD}};
        end
        for (int c = 0; c < A_COLS; c++) begin
            for (int k = 0; k < 2; k++) begin
                w = '0;
                for (int l = 0; l < 16; l++) w[16*l +: 16] = (k*16 + l < A_PIX) ? 16'(c*256 + k*16 + l) : 16'hBEEF;
                mem_a[c*2 + k] = w;
            end
        end
        for (int c = 0; c < B_COLS; c++) begin
            w = '0;
            for (int l = 0; l < 16; l++) w[16*l +: 16] = (l < B_PIX) ? 16'(c*256 + l) : 16'hBEEF;
            mem_b[B_BASE + c] = w;
        end

        repeat (3) @(posedge clk);
        #1 check_zero_a("reset");
        check("reset_b_valid", ib.col_valid, 0);
        check("reset_b_busy", busy_b, 0);
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_zero_a("post_release");

        // Default run, ready tied high
        do_start_a();
        t = 0;
        do begin @(negedge clk); t++; end while (!ia.col_valid && t < 200);
        check("a_first_valid_seen", ia.col_valid, 1);
        check("a_first_valid_latency", cyc - s_cyc, 4);
        wait_done_a(1);
        check("a_run1_handshakes", hs_a, A_COLS);
        check("a_run1_queue_left", q_a.size(), 0);
        check("a_run1_busy_after", busy_a, 0);

        // Stall on column 5
        do_start_a();
        t = 0;
        do begin @(negedge clk); t++; end while (!(ia.col_valid && ia.col_index == 4) && t < 200);
        check("a_col4_seen", ia.col_valid, 1);
        @(posedge clk); #1 ready_a = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!ia.col_valid && t < 200);
        check("a_col5_seen", ia.col_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", ia.col_valid, 1);
            check("stall_index", ia.col_index, 5);
            check("stall_pix0", ia.col_data[0], 5*256);
            check("stall_pix23", ia.col_data[23], 5*256 + 23);
            check("stall_bram_en", ia.bram_en_b, 0);
        end
        @(posedge clk); #1 ready_a = 1'b1;
        wait_done_a(2);
        check("a_run2_handshakes", hs_a, 2*A_COLS);
        check("a_run2_queue_left", q_a.size(), 0);

        // Reset while reading column 7
        hs0 = hs_a;
        do_start_a();
        t = 0;
        do begin @(negedge clk); t++; end while (!(ia.bram_en_b && ia.col_index == 7) && t < 400);
        check("a_col7_read_seen", ia.bram_en_b, 1);
        resetn = 1'b0;
        @(posedge clk); #1 check_zero_a("midreset");
        check("a_hs_before_reset", hs_a - hs0, 7);
        q_a.delete();
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_zero_a("after_midreset");
        do_start_a();
        t = 0;
        do begin @(negedge clk); t++; end while (!ia.col_valid && t < 200);
        check("a_restart_first_index", ia.col_index, 0);
        check("a_restart_latency", cyc - s_cyc, 4);
        wait_done_a(3);
        check("a_run3_queue_left", q_a.size(), 0);

        // Small configuration, extra starts while busy and coincident with done
        do_start_b();
        t = 0;
        do begin @(negedge clk); t++; end while (!ib.col_valid && t < 200);
        check("b_first_valid_seen", ib.col_valid, 1);
        check("b_first_valid_latency", cyc - s_cyc, 3);
        repeat (2) @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!done_b && t < 500);
        check("b_done_seen", done_b, 1);
        start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        repeat (20) @(negedge clk);
        check("b_done_count", done_cnt_b, 1);
        check("b_handshakes", hs_b, B_COLS);
        check("b_queue_left", q_b.size(), 0);
        check("b_busy_after", busy_b, 0);
        check("b_reads_total", rd_b_n, B_COLS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
